// File: rtl/rv32i_types.sv
// Shared RV32I pipeline types: the queued commit entry and the retirement
// record handed to the monitor.
package rv32i_types;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] insn;
    logic [4:0]  rd;
    logic        trap;
  } commit_entry_t;

  typedef struct packed {
    logic        valid;
    logic [31:0] pc_rdata;
    logic [31:0] pc_wdata;
    logic [31:0] insn;
    logic        trap;
    logic [4:0]  rd_addr;
    logic [31:0] rd_wdata;
    logic [63:0] order;
  } commit_record_t;

endpackage

// File: rtl/commit_fifo.sv
// Circular buffer of commit entries with push/pop/clear and an occupancy count.
// A same-cycle pop still reads the head before clear empties the buffer.
module commit_fifo
  import rv32i_types::*;
#(
  parameter int unsigned DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  commit_entry_t            push_entry,
  input  logic                     pop,
  input  logic                     clear,
  output commit_entry_t            head_entry,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     full,
  output logic                     empty
);

  localparam int unsigned PtrW = $clog2(DEPTH);
  localparam logic [PtrW:0] FullCount = (PtrW + 1)'(DEPTH);

  commit_entry_t     mem_q [DEPTH];
  logic [PtrW-1:0]   head_q, tail_q;
  logic [PtrW:0]     count_q;

  // Storage carries no reset; validity is tracked by the pointers and count.
  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[tail_q] <= push_entry;
    end
  end

  always_ff @(posedge clk) begin
    if (rst || clear) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      if (push) tail_q <= tail_q + 1'b1;
      if (pop)  head_q <= head_q + 1'b1;
      count_q <= count_q + {{PtrW{1'b0}}, push} - {{PtrW{1'b0}}, pop};
    end
  end

  assign head_entry = mem_q[head_q];
  assign count      = count_q;
  assign full       = (count_q == FullCount);
  assign empty      = (count_q == '0);

endmodule

// File: rtl/commit_queue.sv
// In-order retirement tracker feeding an RVFI-style monitor.
// Optional COMMIT_QUEUE_TRAP_HALT_EN: retiring a trapped entry halts the queue until reset.
module commit_queue
  import rv32i_types::*;
#(
  parameter int unsigned DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push_valid,
  input  logic                     push_commit,
  output logic                     push_ready,
  input  logic [31:0]              push_pc,
  input  logic [31:0]              push_insn,
  input  logic [4:0]               push_rd,
  input  logic                     push_trap,
  input  logic                     wb_valid,
  input  logic [31:0]              wb_pc_next,
  input  logic [31:0]              wb_rd_wdata,
  input  logic                     flush,
  output logic                     mon_valid,
  output logic [31:0]              mon_pc_rdata,
  output logic [31:0]              mon_pc_wdata,
  output logic [31:0]              mon_insn,
  output logic                     mon_trap,
  output logic [4:0]               mon_rd_addr,
  output logic [31:0]              mon_rd_wdata,
  output logic [63:0]              mon_order,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     err
);

  commit_entry_t  push_entry, head_entry;
  commit_record_t rec_q;
  logic [63:0]    order_q;
  logic           err_q;
  logic           halted;
  logic           full, empty;
  logic           do_push, do_pop, bad_pop;

  assign push_entry = '{pc: push_pc, insn: push_insn, rd: push_rd, trap: push_trap};

  // push_ready comes from registered state only, so wb_valid never reaches it.
  assign push_ready = !full && !halted;
  assign do_push    = push_valid && push_commit && push_ready && !flush;
  assign do_pop     = wb_valid && !empty && !halted;
  assign bad_pop    = wb_valid && empty && !halted;

  commit_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk        (clk),
    .rst        (rst),
    .push       (do_push),
    .push_entry (push_entry),
    .pop        (do_pop),
    .clear      (flush),
    .head_entry (head_entry),
    .count      (count),
    .full       (full),
    .empty      (empty)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      rec_q   <= '0;
      order_q <= '0;
      err_q   <= 1'b0;
    end else begin
      rec_q.valid <= do_pop;
      if (do_pop) begin
        rec_q.pc_rdata <= head_entry.pc;
        rec_q.pc_wdata <= wb_pc_next;
        rec_q.insn     <= head_entry.insn;
        rec_q.trap     <= head_entry.trap;
        rec_q.rd_addr  <= head_entry.rd;
        rec_q.rd_wdata <= (head_entry.rd == 5'd0) ? 32'd0 : wb_rd_wdata;
        rec_q.order    <= order_q;
        order_q        <= order_q + 64'd1;
      end
      if (bad_pop) err_q <= 1'b1;
    end
  end

`ifdef COMMIT_QUEUE_TRAP_HALT_EN
  logic halted_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      halted_q <= 1'b0;
    end else if (do_pop && head_entry.trap) begin
      halted_q <= 1'b1;
    end
  end

  assign halted = halted_q;
`else
  assign halted = 1'b0;
`endif

  assign mon_valid    = rec_q.valid;
  assign mon_pc_rdata = rec_q.pc_rdata;
  assign mon_pc_wdata = rec_q.pc_wdata;
  assign mon_insn     = rec_q.insn;
  assign mon_trap     = rec_q.trap;
  assign mon_rd_addr  = rec_q.rd_addr;
  assign mon_rd_wdata = rec_q.rd_wdata;
  assign mon_order    = rec_q.order;
  assign err          = err_q;

endmodule

// File: tb/tb_commit_queue.sv
// Directed bench for commit_queue with a queue model and retirement scoreboard.
module tb_commit_queue;
  import rv32i_types::*;

  localparam int unsigned DEPTH = 8;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        push_valid = 1'b0, push_commit = 1'b0, push_trap = 1'b0;
  logic [31:0] push_pc = '0, push_insn = '0;
  logic [4:0]  push_rd = '0;
  logic        wb_valid = 1'b0, flush = 1'b0;
  logic [31:0] wb_pc_next = '0, wb_rd_wdata = '0;
  logic        push_ready, mon_valid, mon_trap, err;
  logic [31:0] mon_pc_rdata, mon_pc_wdata, mon_insn, mon_rd_wdata;
  logic [4:0]  mon_rd_addr;
  logic [63:0] mon_order;
  logic [$clog2(DEPTH):0] count;

  commit_queue #(.DEPTH(DEPTH)) dut (
    .clk          (clk),
    .rst          (rst),
    .push_valid   (push_valid),
    .push_commit  (push_commit),
    .push_ready   (push_ready),
    .push_pc      (push_pc),
    .push_insn    (push_insn),
    .push_rd      (push_rd),
    .push_trap    (push_trap),
    .wb_valid     (wb_valid),
    .wb_pc_next   (wb_pc_next),
    .wb_rd_wdata  (wb_rd_wdata),
    .flush        (flush),
    .mon_valid    (mon_valid),
    .mon_pc_rdata (mon_pc_rdata),
    .mon_pc_wdata (mon_pc_wdata),
    .mon_insn     (mon_insn),
    .mon_trap     (mon_trap),
    .mon_rd_addr  (mon_rd_addr),
    .mon_rd_wdata (mon_rd_wdata),
    .mon_order    (mon_order),
    .count        (count),
    .err          (err)
  );

  always #5 clk = ~clk;

  int total = 0;
  int passed = 0;

  // Reference state
  commit_entry_t  mq [$];
  commit_record_t exp_q [$];
  logic           m_err = 1'b0, m_halt = 1'b0;
  logic [63:0]    m_order = '0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  // Apply the currently driven inputs to the model, clock once, then check.
  task automatic tick();
    logic ready, pop_ok, push_ok, exp_valid;
    commit_entry_t  e;
    commit_record_t r;
    ready     = (mq.size() < DEPTH) && !m_halt;
    pop_ok    = wb_valid && (mq.size() != 0) && !m_halt;
    push_ok   = push_valid && push_commit && ready && !flush;
    exp_valid = pop_ok;
    if (wb_valid && mq.size() == 0 && !m_halt) m_err = 1'b1;
    if (pop_ok) begin
      e = mq.pop_front();
      r.valid    = 1'b1;
      r.pc_rdata = e.pc;
      r.pc_wdata = wb_pc_next;
      r.insn     = e.insn;
      r.trap     = e.trap;
      r.rd_addr  = e.rd;
      r.rd_wdata = (e.rd == 0) ? 32'd0 : wb_rd_wdata;
      r.order    = m_order;
      m_order    = m_order + 1;
      exp_q.push_back(r);
`ifdef COMMIT_QUEUE_TRAP_HALT_EN
      if (e.trap) m_halt = 1'b1;
`endif
    end
    if (flush) mq.delete();
    else if (push_ok) mq.push_back('{pc: push_pc, insn: push_insn, rd: push_rd, trap: push_trap});
    @(posedge clk);
    #1;
    chk("mon_valid", mon_valid, exp_valid);
    if (mon_valid && exp_q.size() != 0) begin
      r = exp_q.pop_front();
      chk("mon_pc_rdata", mon_pc_rdata, r.pc_rdata);
      chk("mon_pc_wdata", mon_pc_wdata, r.pc_wdata);
      chk("mon_insn", mon_insn, r.insn);
      chk("mon_trap", mon_trap, r.trap);
      chk("mon_rd_addr", mon_rd_addr, r.rd_addr);
      chk("mon_rd_wdata", mon_rd_wdata, r.rd_wdata);
      chk("mon_order", mon_order, r.order);
    end
    chk("count", count, mq.size());
    chk("err", err, m_err);
    chk("push_ready", push_ready, (mq.size() < DEPTH) && !m_halt);
  endtask

  task automatic drive(input logic pv, input logic pcm, input logic [31:0] pc,
                       input logic [31:0] insn, input logic [4:0] rd, input logic trap,
                       input logic wv, input logic [31:0] wpn, input logic [31:0] wrd,
                       input logic fl);
    push_valid = pv; push_commit = pcm; push_pc = pc; push_insn = insn;
    push_rd = rd; push_trap = trap; wb_valid = wv; wb_pc_next = wpn;
    wb_rd_wdata = wrd; flush = fl;
    tick();
  endtask

  task automatic do_push(input logic [31:0] pc, input logic [4:0] rd, input logic trap);
    drive(1'b1, 1'b1, pc, 32'h13 | (32'(rd) << 7), rd, trap, 1'b0, '0, '0, 1'b0);
  endtask

  task automatic do_pop(input logic [31:0] pcn, input logic [31:0] wd);
    drive(1'b0, 1'b0, '0, '0, '0, 1'b0, 1'b1, pcn, wd, 1'b0);
  endtask

  task automatic idle();
    drive(1'b0, 1'b0, '0, '0, '0, 1'b0, 1'b0, '0, '0, 1'b0);
  endtask

  task automatic do_reset();
    push_valid = 1'b0; wb_valid = 1'b0; flush = 1'b0;
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    mq.delete(); exp_q.delete();
    m_err = 1'b0; m_halt = 1'b0; m_order = '0;
  endtask

  initial begin
    // Reset state
    @(posedge clk);
    do_reset();
    chk("rst_mon_valid", mon_valid, 1'b0);
    chk("rst_mon_order", mon_order, 64'd0);
    chk("rst_mon_pc_rdata", mon_pc_rdata, 32'd0);
    chk("rst_count", count, 0);
    chk("rst_push_ready", push_ready, 1'b1);
    chk("rst_err", err, 1'b0);

    // Fill to capacity, then one more push that must be refused
    for (int i = 0; i < 8; i++) do_push(32'h60 + 32'(4 * i), 5'(i + 1), 1'b0);
    chk("full_push_ready", push_ready, 1'b0);
    chk("full_count", count, 8);
    do_push(32'hFF0, 5'd9, 1'b0);
    chk("full_count_hold", count, 8);

    // Drain in order
    for (int i = 0; i < 8; i++) begin
      do_pop(32'h64 + 32'(4 * i), 32'h11 * 32'(i));
      chk("drain_pc", mon_pc_rdata, 32'h60 + 32'(4 * i));
      chk("drain_order", mon_order, 64'(i));
    end
    idle();
    chk("drain_count", count, 0);
    chk("drain_valid_drop", mon_valid, 1'b0);

    // Non-committing entry is discarded
    drive(1'b1, 1'b0, 32'h500, 32'h13, 5'd1, 1'b0, 1'b0, '0, '0, 1'b0);
    chk("discard_count", count, 0);

    // Simultaneous push and pop at count 3
    for (int i = 0; i < 3; i++) do_push(32'h700 + 32'(4 * i), 5'd4, 1'b0);
    drive(1'b1, 1'b1, 32'h70C, 32'h33, 5'd5, 1'b0, 1'b1, 32'h704, 32'h1234, 1'b0);
    chk("pushpop_count", count, 3);
    chk("pushpop_pc", mon_pc_rdata, 32'h700);
    for (int i = 0; i < 3; i++) do_pop(32'h708 + 32'(4 * i), 32'hA0 + 32'(i));

    // Branch target and rd zeroing
    do_push(32'h80, 5'd0, 1'b0);
    do_push(32'h84, 5'd0, 1'b0);
    do_pop(32'h40, 32'h0);
    chk("branch_pc_wdata", mon_pc_wdata, 32'h40);
    do_pop(32'h88, 32'hDEADBEEF);
    chk("rd0_wdata", mon_rd_wdata, 32'h0);

    // Flush with concurrent pop and push
    for (int i = 0; i < 4; i++) do_push(32'h100 + 32'(4 * i), 5'd6, 1'b0);
    drive(1'b1, 1'b1, 32'h200, 32'h13, 5'd7, 1'b0, 1'b1, 32'h104, 32'h55, 1'b1);
    chk("flush_mon_valid", mon_valid, 1'b1);
    chk("flush_pc", mon_pc_rdata, 32'h100);
    chk("flush_count", count, 0);
    do_push(32'h300, 5'd8, 1'b0);
    do_pop(32'h304, 32'h77);
    chk("flush_push_absent", mon_pc_rdata, 32'h300);

    // Protocol error: pop from empty, sticky until reset
    do_pop(32'h0, 32'h0);
    chk("err_no_valid", mon_valid, 1'b0);
    chk("err_set", err, 1'b1);
    do_push(32'h900, 5'd2, 1'b0);
    do_pop(32'h904, 32'h9);
    chk("err_sticky", err, 1'b1);
    do_reset();
    chk("err_cleared", err, 1'b0);
    chk("order_reset", mon_order, 64'd0);

    // Trap entry retirement
    do_push(32'h400, 5'd3, 1'b1);
    do_push(32'h404, 5'd3, 1'b0);
    do_pop(32'h404, 32'hBB);
    chk("trap_mon_trap", mon_trap, 1'b1);
`ifdef COMMIT_QUEUE_TRAP_HALT_EN
    chk("halt_push_ready", push_ready, 1'b0);
    do_pop(32'h408, 32'hCC);
    chk("halt_no_valid", mon_valid, 1'b0);
    chk("halt_no_err", err, 1'b0);
`else
    do_pop(32'h408, 32'hCC);
    chk("post_trap_pc", mon_pc_rdata, 32'h404);
    chk("post_trap_trap", mon_trap, 1'b0);
    chk("post_trap_order", mon_order, 64'd1);
`endif
    idle();

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
